// File: rtl/key_conditioner.sv
// Push-button conditioner: per-key two-flop synchroniser, debounce counter and
// IDLE/HELD/LONG tracker producing a debounced level plus press/release/long pulses.
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] pressed,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic              any_held
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_e;

    logic [N_KEYS-1:0]              sync1_q, sync2_q;
    logic [N_KEYS-1:0][DB_W-1:0]    db_cnt_q, db_cnt_d;
    logic [N_KEYS-1:0][HOLD_W-1:0]  hold_q, hold_d;
    logic [N_KEYS-1:0]              pressed_q, pressed_d;
    logic [N_KEYS-1:0]              press_q, press_d;
    logic [N_KEYS-1:0]              release_q, release_d;
    logic [N_KEYS-1:0]              long_q, long_d;
    logic                           any_q, any_d;
    logic [N_KEYS-1:0]              s_w, accept_w;
    state_e                         state_q [N_KEYS];
    state_e                         state_d [N_KEYS];

    assign s_w = ~sync2_q;

    // A change is accepted on the edge where the opposing level has been stable long enough.
    always_comb begin
        accept_w = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            accept_w[k] = (s_w[k] != pressed_q[k]) && (db_cnt_q[k] == DB_LAST);
        end
    end

    always_comb begin
        db_cnt_d  = db_cnt_q;
        hold_d    = hold_q;
        pressed_d = pressed_q ^ accept_w;
        press_d   = '0;
        release_d = '0;
        long_d    = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            state_d[k] = state_q[k];
            if (s_w[k] == pressed_q[k] || accept_w[k]) begin
                db_cnt_d[k] = '0;
            end else begin
                db_cnt_d[k] = db_cnt_q[k] + DB_W'(1);
            end
            case (state_q[k])
                ST_IDLE: begin
                    if (accept_w[k]) begin
                        state_d[k] = ST_HELD;
                        hold_d[k]  = '0;
                        press_d[k] = 1'b1;
                    end
                end
                ST_HELD: begin
                    // Release wins over a coincident long-press threshold.
                    if (accept_w[k]) begin
                        state_d[k]   = ST_IDLE;
                        hold_d[k]    = '0;
                        release_d[k] = 1'b1;
                    end else if (hold_q[k] == HOLD_LAST) begin
                        state_d[k] = ST_LONG;
                        long_d[k]  = 1'b1;
                    end else begin
                        hold_d[k] = hold_q[k] + HOLD_W'(1);
                    end
                end
                ST_LONG: begin
                    if (accept_w[k]) begin
                        state_d[k]   = ST_IDLE;
                        hold_d[k]    = '0;
                        release_d[k] = 1'b1;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    hold_d[k]  = '0;
                end
            endcase
        end
        any_d = |pressed_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_cnt_q  <= '0;
            hold_q    <= '0;
            pressed_q <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            any_q     <= 1'b0;
            for (int k = 0; k < N_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
            end
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            hold_q    <= hold_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            any_q     <= any_d;
            for (int k = 0; k < N_KEYS; k++) begin
                state_q[k] <= state_d[k];
            end
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign any_held      = any_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=16:
// per-cycle pulse bookkeeping, then hand-computed cycle/count expectations.
module tb_key_conditioner;

    localparam int NK = 4;

    logic          clk;
    logic          reset;
    logic [NK-1:0] key_n;
    logic [NK-1:0] pressed, press_pulse, release_pulse, long_pulse;
    logic          any_held;

    key_conditioner #(
        .N_KEYS(NK),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .key_n(key_n),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .long_pulse(long_pulse),
        .any_held(any_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int np[NK], nr[NK], nl[NK];
    int pc[NK], rc[NK], lc[NK];
    int held_seen[NK];
    int excl_err, any_err, any0_err;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        for (int k = 0; k < NK; k++) begin
            np[k] = 0; nr[k] = 0; nl[k] = 0;
            pc[k] = -1; rc[k] = -1; lc[k] = -1;
            held_seen[k] = 0;
        end
        excl_err = 0;
        any_err  = 0;
        any0_err = 0;
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            for (int k = 0; k < NK; k++) begin
                if (press_pulse[k] === 1'b1)   begin np[k]++; pc[k] = cyc; end
                if (release_pulse[k] === 1'b1) begin nr[k]++; rc[k] = cyc; end
                if (long_pulse[k] === 1'b1)    begin nl[k]++; lc[k] = cyc; end
                if (pressed[k] === 1'b1) held_seen[k] = 1;
                if ((int'(press_pulse[k]) + int'(release_pulse[k]) + int'(long_pulse[k])) > 1)
                    excl_err++;
            end
            if (any_held !== (|pressed)) any_err++;
            if (any_held !== pressed[0]) any0_err++;
        end
    endtask

    int c0;

    initial begin
        reset = 1'b0;
        key_n = 4'b1110;
        clr_stats();

        // 1: reset with key 0 held
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("rst_outputs", int'({pressed, press_pulse, release_pulse, long_pulse, any_held}), 0);
        end
        reset = 1'b1;
        clr_stats();
        c0 = cyc;
        tick(5);
        check("s1_no_press_early", np[0], 0);
        tick(1);
        check("s1_press_pulse_now", int'(press_pulse[0]), 1);
        tick(6);
        check("s1_press_count", np[0], 1);
        check("s1_press_cycle", pc[0] - c0, 6);
        check("s1_pressed_level", int'(pressed[0]), 1);
        check("s1_no_release", nr[0], 0);
        key_n = 4'b1111;
        clr_stats();
        c0 = cyc;
        tick(10);
        check("s1_release_cycle", rc[0] - c0, 6);
        check("s1_pressed_cleared", int'(pressed[0]), 0);

        // 2: 3-cycle glitch on key 1
        clr_stats();
        key_n[1] = 1'b0;
        tick(3);
        key_n[1] = 1'b1;
        tick(12);
        check("s2_never_pressed", held_seen[1], 0);
        check("s2_no_press", np[1], 0);
        check("s2_no_release", nr[1], 0);

        // 3: key 2 bouncing every 2 cycles, then held
        clr_stats();
        for (int i = 0; i < 10; i++) begin
            key_n[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(2);
        end
        check("s3_bounce_no_press", np[2], 0);
        key_n[2] = 1'b0;
        c0 = cyc;
        tick(12);
        check("s3_press_count", np[2], 1);
        check("s3_press_cycle", pc[2] - c0, 6);
        check("s3_no_release_bounce", nr[2], 0);
        key_n[2] = 1'b1;
        tick(12);
        check("s3_release_after", nr[2], 1);

        // 4: long press on key 3
        clr_stats();
        key_n[3] = 1'b0;
        c0 = cyc;
        tick(60);
        key_n[3] = 1'b1;
        tick(12);
        check("s4_press_count", np[3], 1);
        check("s4_press_cycle", pc[3] - c0, 6);
        check("s4_long_count", nl[3], 1);
        check("s4_long_delay", lc[3] - pc[3], 16);
        check("s4_release_count", nr[3], 1);
        check("s4_release_cycle", rc[3] - c0, 66);

        // 5: short press on key 0
        clr_stats();
        key_n[0] = 1'b0;
        c0 = cyc;
        tick(12);
        key_n[0] = 1'b1;
        tick(12);
        check("s5_press_count", np[0], 1);
        check("s5_release_count", nr[0], 1);
        check("s5_release_cycle", rc[0] - c0, 18);
        check("s5_no_long", nl[0], 0);
        check("s5_any_mirrors_key0", any0_err, 0);

        // 6: keys 0 and 2 together, then a one-cycle reset mid-hold
        clr_stats();
        key_n = 4'b1010;
        c0 = cyc;
        tick(8);
        check("s6_press0_cycle", pc[0] - c0, 6);
        check("s6_press2_cycle", pc[2] - c0, 6);
        check("s6_any_held", int'(any_held), 1);
        reset = 1'b0;
        tick(1);
        check("s6_reset_clears", int'({pressed, press_pulse, release_pulse, long_pulse, any_held}), 0);
        reset = 1'b1;
        clr_stats();
        c0 = cyc;
        tick(10);
        check("s6_repress0_cycle", pc[0] - c0, 6);
        check("s6_repress2_cycle", pc[2] - c0, 6);
        check("s6_repress_counts", np[0] + np[2], 2);
        check("s6_no_release", nr[0] + nr[2], 0);
        check("s6_pressed_level", int'(pressed), 5);
        check("pulse_exclusive", excl_err, 0);
        check("any_held_is_or", any_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
